fifo_conteo: RTL
================

// Module: fifo_conteo
// PURPOSE
//  Synchronous FIFO that buffers DATA_WIDTH-bit words ahead of the push-event
//  counter (contador). Every write it accepts raises push_ok for exactly one
//  clock; push_ok drives the counter's push input, so the counter tallies
//  accepted writes only, never dropped ones. Also reports flags, occupancy and
//  sticky overflow/underflow errors.
// PARAMETERS
//  DATA_WIDTH   6  width of the stored word
//  ADDR_WIDTH   3  pointer width; DEPTH = 2**ADDR_WIDTH = 8 entries
//  AF_TH        6  almost_full asserts when occupancy >= AF_TH
//  AE_TH        2  almost_empty asserts when occupancy <= AE_TH
// PORTS
//  clk           in   1            rising-edge clock
//  reset_L       in   1            asynchronous reset, active-low
//  push          in   1            write request
//  data_in       in   DATA_WIDTH   write data, sampled with push
//  pop           in   1            read request
//  data_out      out  DATA_WIDTH   read data, registered
//  valid_out     out  1            data_out valid, 1-cycle pulse
//  push_ok       out  1            accepted-write strobe to contador.push
//  full          out  1            occupancy == DEPTH
//  empty         out  1            occupancy == 0
//  almost_full   out  1            occupancy >= AF_TH
//  almost_empty  out  1            occupancy <= AE_TH
//  ocupacion     out  ADDR_WIDTH+1 number of stored words, 0..DEPTH
//  error         out  1            sticky: overflow or underflow occurred
// BEHAVIOUR
//  Reset (reset_L=0, async): wr_ptr=rd_ptr=0, ocupacion=0, data_out=0,
//   valid_out=0, push_ok=0, error=0, so empty=1, almost_empty=1, full=0,
//   almost_full=0. Memory contents are not cleared. Outputs hold reset values
//   while reset_L=0. Reset mid-operation discards all stored words.
//  Accept rules, evaluated on each rising edge using the pre-edge state:
//   write_acc = push & (~full | pop)
//   read_acc  = pop & ~empty
//  Write: mem[wr_ptr]<=data_in; wr_ptr<=wr_ptr+1 (wraps modulo DEPTH).
//  Read: data_out<=mem[rd_ptr]; rd_ptr<=rd_ptr+1 (wraps modulo DEPTH).
//   valid_out=1 in the cycle after the pop, so latency is 1 clock.
//   With no read, valid_out=0 and data_out holds its last value.
//  push_ok is registered: push_ok = write_acc of the previous edge. It aligns
//   with the counter's sampling edge, so each accepted write gives +1 count.
//  ocupacion: +1 on write only; -1 on read only; unchanged on both or neither.
//   Flags are combinational from the registered ocupacion.
//  Boundary cases:
//   - full & push & ~pop: write dropped, push_ok=0, error<=1 (overflow).
//   - full & push & pop: both accepted, ocupacion stays DEPTH, push_ok=1.
//   - empty & pop: read ignored, valid_out=0, error<=1 (underflow).
//   - empty & push & pop: write accepted, read ignored, error<=1,
//     ocupacion becomes 1. There is no fall-through.
//   - error clears only on reset.
//  No X on any output after reset. Pointers use ADDR_WIDTH bits. ocupacion
//   never exceeds DEPTH.
// TESTING
//  1 Reset: hold reset_L=0 3 cycles with push=1 -> empty=1, ocupacion=0,
//    push_ok=0, error=0. Also assert reset_L=0 mid-burst -> outputs clear at
//    once, without waiting for a clock edge.
//  2 Fill: 8 pushes of 1..8 -> 8 push_ok pulses, full=1 after the 8th,
//    almost_full at ocupacion=6, contador.cuenta=8.
//  3 Overflow: 9th push while full -> push_ok=0, error=1, ocupacion=8,
//    cuenta stays 8.
//  4 Drain: 8 pops -> data_out 1..8 in order, one cycle after each pop, with
//    valid_out=1; empty=1 at end, almost_empty at ocupacion=2.
//  5 Simultaneous: push+pop when full -> ocupacion=8, push_ok=1. Push+pop when
//    empty -> ocupacion=1, valid_out=0, error=1.
//  6 Wrap: 20 interleaved push/pop with random data -> output order matches a
//    scoreboard, and the pointers wrap past 7 cleanly.

Source files
------------

// File: rtl/fifo_conteo.sv
// Synchronous FIFO with registered read data, occupancy flags, a sticky error bit
// and a one-cycle accepted-write strobe (push_ok) for the downstream push counter.
module fifo_conteo #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_TH      = 6,
  parameter int AE_TH      = 2
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  push_ok,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   ocupacion,
  output logic                  error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_V = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_V    = (ADDR_WIDTH+1)'(AF_TH);
  localparam logic [ADDR_WIDTH:0]   AE_V    = (ADDR_WIDTH+1)'(AE_TH);
  localparam logic [ADDR_WIDTH:0]   OCC_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   occ_q, occ_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  push_ok_q, push_ok_d;
  logic                  error_q, error_d;
  logic                  write_acc, read_acc;

  assign full         = (occ_q == DEPTH_V);
  assign empty        = (occ_q == '0);
  assign almost_full  = (occ_q >= AF_V);
  assign almost_empty = (occ_q <= AE_V);

  // A pop frees a slot in the same edge, so a full FIFO still accepts push+pop.
  assign write_acc = push & (~full | pop);
  assign read_acc  = pop & ~empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    data_out_d = data_out_q;
    valid_d    = read_acc;
    push_ok_d  = write_acc;
    error_d    = error_q | (push & full & ~pop) | (pop & empty);
    if (write_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (read_acc) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      data_out_d = mem_q[rd_ptr_q];
    end
    case ({write_acc, read_acc})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      push_ok_q  <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      push_ok_q  <= push_ok_d;
      error_q    <= error_d;
    end
  end

  // Storage is deliberately not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (write_acc) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_q;
  assign push_ok   = push_ok_q;
  assign ocupacion = occ_q;
  assign error     = error_q;

endmodule
